// File: rtl/v_lane_valid_gen.sv
// v_lane_valid_gen: per-lane element-valid generator for the vector control
// unit. Walks a vector op one lane group per shift over [vstart, vl), applies
// the v0 mask, remembers which lanes received data, then sequences the
// partial-result valids of a serial or tree reduction.
module v_lane_valid_gen #(
    parameter int VLANE_NUM       = 8,
    parameter int MAX_VL_PER_LANE = 256
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          load_i,
    input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE):0]    vl_i,
    input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE):0]    vstart_i,
    input  logic                                          vm_i,
    input  logic [1:0]                                    red_mode_i,
    input  logic                                          shift_en_i,
    input  logic [VLANE_NUM-1:0]                          mask_i,
    input  logic                                          shift_partial_i,
    output logic [VLANE_NUM-1:0]                          valid_o,
    output logic                                          last_group_o,
    output logic [VLANE_NUM-2:0]                          partial_valid_o,
    output logic                                          busy_o,
    output logic                                          done_o
);

    localparam int VL_W = $clog2(VLANE_NUM*MAX_VL_PER_LANE) + 1;
    localparam int LW   = $clog2(VLANE_NUM);
    localparam int GW   = $clog2(MAX_VL_PER_LANE);
    localparam int GRW  = VL_W - LW;   // group index width incl. one spare bit
    localparam int SW   = LW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REDUCE = 2'd2
    } state_t;

    // Lanes at or above the given lane offset.
    function automatic logic [VLANE_NUM-1:0] ge_mask(input logic [LW-1:0] b);
        logic [VLANE_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < VLANE_NUM; i++) begin
            m[i] = (LW'(i) >= b);
        end
        return m;
    endfunction

    // Lanes at or below the given lane offset.
    function automatic logic [VLANE_NUM-1:0] le_mask(input logic [LW-1:0] b);
        logic [VLANE_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < VLANE_NUM; i++) begin
            m[i] = (LW'(i) <= b);
        end
        return m;
    endfunction

    // Serial reduction: lane step+1 folds into the accumulator if it got data.
    function automatic logic [VLANE_NUM-2:0] serial_mask(input logic [VLANE_NUM-1:0] used,
                                                         input logic [SW-1:0] step);
        logic [VLANE_NUM-2:0] pv;
        pv = '0;
        for (int i = 0; i < VLANE_NUM-1; i++) begin
            pv[i] = (int'(step) == i) && used[i+1];
        end
        return pv;
    endfunction

    // Tree reduction: at step s, lane j (j mod 2^(s+1) == 2^s) sends its
    // partial to lane j-2^s if any lane of its 2^s-wide block received data.
    function automatic logic [VLANE_NUM-2:0] tree_mask(input logic [VLANE_NUM-1:0] used,
                                                       input logic [SW-1:0] step);
        logic [VLANE_NUM-2:0] pv;
        logic                 any;
        int                   span;
        pv   = '0;
        span = 1 << int'(step);
        for (int j = 1; j < VLANE_NUM; j++) begin
            if ((j % (2*span)) == span) begin
                any = 1'b0;
                for (int k = 0; k < VLANE_NUM; k++) begin
                    if ((k >= j) && (k < j + span)) begin
                        any = any | used[k];
                    end else begin
                        any = any;
                    end
                end
                pv[j-1] = any;
            end else begin
                pv[j-1] = 1'b0;
            end
        end
        return pv;
    endfunction

    state_t               state_r, state_n;
    logic [GW-1:0]        grp_r, grp_n;
    logic [SW-1:0]        step_r, step_n;
    logic [VLANE_NUM-1:0] lane_used_r, used_n;
    logic                 done_r, done_n;
    logic [GRW-1:0]       sg_r, eg_r;
    logic [VLANE_NUM-1:0] first_mask_r, last_mask_r;
    logic                 vm_r;
    logic [1:0]           red_mode_r;

    logic [VL_W-1:0]      vl_m1_s;
    logic [GRW-1:0]       sg_s;
    logic                 empty_s;
    logic                 at_sg_s, at_eg_s;
    logic [VLANE_NUM-1:0] gmask_s, valid_s;
    logic [VLANE_NUM-2:0] partial_s;
    logic [SW-1:0]        last_step_s;
    logic                 reduce_mode_s;

    assign vl_m1_s       = vl_i - VL_W'(1);
    assign sg_s          = vstart_i[VL_W-1:LW];
    assign empty_s       = (vl_i == VL_W'(0)) || (vstart_i >= vl_i);
    assign at_sg_s       = ({1'b0, grp_r} == sg_r);
    assign at_eg_s       = ({1'b0, grp_r} == eg_r);
    assign reduce_mode_s = (red_mode_r == 2'b01) || (red_mode_r == 2'b10);

    // Group mask, lane valids and reduction step sequencing for the current state.
    always_comb begin
        gmask_s     = {VLANE_NUM{1'b1}};
        valid_s     = '0;
        partial_s   = '0;
        last_step_s = SW'(VLANE_NUM-2);
        if (at_sg_s) begin
            gmask_s = gmask_s & first_mask_r;
        end else begin
            gmask_s = gmask_s;
        end
        if (at_eg_s) begin
            gmask_s = gmask_s & last_mask_r;
        end else begin
            gmask_s = gmask_s;
        end
        if (state_r == ACTIVE) begin
            valid_s = gmask_s & {VLANE_NUM{shift_en_i}} & (vm_r ? {VLANE_NUM{1'b1}} : mask_i);
        end else begin
            valid_s = '0;
        end
        case (red_mode_r)
            2'b01: begin
                last_step_s = SW'(VLANE_NUM-2);
                partial_s   = serial_mask(lane_used_r, step_r);
            end
            2'b10: begin
                last_step_s = SW'(LW-1);
                partial_s   = tree_mask(lane_used_r, step_r);
            end
            default: begin
                last_step_s = SW'(VLANE_NUM-2);
                partial_s   = '0;
            end
        endcase
        if (state_r != REDUCE) begin
            partial_s = '0;
        end else begin
            partial_s = partial_s;
        end
    end

    // Next-state logic: load aborts/restarts, then lane shifts, then reduction steps.
    always_comb begin
        state_n = state_r;
        grp_n   = grp_r;
        step_n  = step_r;
        used_n  = lane_used_r;
        done_n  = 1'b0;
        if (load_i) begin
            step_n = '0;
            if (empty_s) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = ACTIVE;
                grp_n   = sg_s[GW-1:0];
                used_n  = '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = IDLE;
                end
                ACTIVE: begin
                    if (shift_en_i) begin
                        used_n = lane_used_r | valid_s;
                        if (at_eg_s) begin
                            step_n = '0;
                            if (reduce_mode_s) begin
                                state_n = REDUCE;
                            end else begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            grp_n = grp_r + GW'(1);
                        end
                    end else begin
                        grp_n = grp_r;
                    end
                end
                REDUCE: begin
                    if (shift_partial_i) begin
                        if (step_r == last_step_s) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            step_n = step_r + SW'(1);
                        end
                    end else begin
                        step_n = step_r;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state, counters, lane-used record and done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            grp_r       <= '0;
            step_r      <= '0;
            lane_used_r <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            grp_r       <= grp_n;
            step_r      <= step_n;
            lane_used_r <= used_n;
            done_r      <= done_n;
        end
    end

    // Op configuration captured at load: group bounds, edge masks, vm, reduction mode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sg_r         <= '0;
            eg_r         <= '0;
            first_mask_r <= '0;
            last_mask_r  <= '0;
            vm_r         <= 1'b0;
            red_mode_r   <= 2'b00;
        end else if (load_i) begin
            sg_r         <= sg_s;
            eg_r         <= vl_m1_s[VL_W-1:LW];
            first_mask_r <= ge_mask(vstart_i[LW-1:0]);
            last_mask_r  <= le_mask(vl_m1_s[LW-1:0]);
            vm_r         <= vm_i;
            red_mode_r   <= red_mode_i;
        end else begin
            sg_r         <= sg_r;
            eg_r         <= eg_r;
            first_mask_r <= first_mask_r;
            last_mask_r  <= last_mask_r;
            vm_r         <= vm_r;
            red_mode_r   <= red_mode_r;
        end
    end

    assign valid_o         = valid_s;
    assign last_group_o    = (state_r == ACTIVE) && at_eg_s;
    assign partial_valid_o = partial_s;
    assign busy_o          = (state_r != IDLE);
    assign done_o          = done_r;

endmodule

// File: tb/tb_v_lane_valid_gen.sv
// Testbench for v_lane_valid_gen (V=8). Directed per-cycle vectors push the
// hand-computed outputs into a scoreboard queue; a monitor on the falling
// edge pops and compares them against the DUT.
module tb_v_lane_valid_gen;

    logic        clk = 1'b0;
    logic        rst_i, load_i, vm_i, shift_en_i, shift_partial_i;
    logic [11:0] vl_i, vstart_i;
    logic [1:0]  red_mode_i;
    logic [7:0]  mask_i;
    logic [7:0]  valid_o;
    logic        last_group_o, busy_o, done_o;
    logic [6:0]  partial_valid_o;

    typedef struct packed {
        logic [15:0] seq;
        logic [7:0]  v;
        logic        l;
        logic [6:0]  pv;
        logic        b;
        logic        d;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   seq_cnt  = 0;

    v_lane_valid_gen #(.VLANE_NUM(8), .MAX_VL_PER_LANE(256)) dut (
        .clk_i(clk), .rst_i(rst_i), .load_i(load_i), .vl_i(vl_i), .vstart_i(vstart_i),
        .vm_i(vm_i), .red_mode_i(red_mode_i), .shift_en_i(shift_en_i), .mask_i(mask_i),
        .shift_partial_i(shift_partial_i), .valid_o(valid_o), .last_group_o(last_group_o),
        .partial_valid_o(partial_valid_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and record the outputs expected during that cycle.
    task automatic cyc(input logic r, input logic ld, input int vl, input int vs,
                       input logic vm, input logic [1:0] md, input logic sh,
                       input logic [7:0] mk, input logic sp,
                       input logic [7:0] ev, input logic el, input logic [6:0] epv,
                       input logic eb, input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = r; load_i = ld; vl_i = 12'(vl); vstart_i = 12'(vs); vm_i = vm;
        red_mode_i = md; shift_en_i = sh; mask_i = mk; shift_partial_i = sp;
        e.seq = 16'(seq_cnt); e.v = ev; e.l = el; e.pv = epv; e.b = eb; e.d = ed;
        seq_cnt++;
        exp_q.push_back(e);
    endtask

    task automatic ld_op(input int vl, input int vs, input logic vm, input logic [1:0] md,
                         input logic [7:0] ev, input logic el, input logic [6:0] epv,
                         input logic eb, input logic ed);
        cyc(1'b0, 1'b1, vl, vs, vm, md, 1'b0, 8'h00, 1'b0, ev, el, epv, eb, ed);
    endtask

    task automatic run(input logic sh, input logic [7:0] mk, input logic sp,
                       input logic [7:0] ev, input logic el, input logic [6:0] epv,
                       input logic eb, input logic ed);
        cyc(1'b0, 1'b0, 0, 0, 1'b0, 2'b00, sh, mk, sp, ev, el, epv, eb, ed);
    endtask

    // Scoreboard monitor: compare each expected cycle against the DUT outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (valid_o !== e.v || last_group_o !== e.l || partial_valid_o !== e.pv ||
                busy_o !== e.b || done_o !== e.d) begin
                failures++;
                $display("FAIL cycle%0d: got valid=%h last=%b pv=%h busy=%b done=%b, expected valid=%h last=%b pv=%h busy=%b done=%b",
                         e.seq, valid_o, last_group_o, partial_valid_o, busy_o, done_o,
                         e.v, e.l, e.pv, e.b, e.d);
            end
        end
    end

    initial begin
        rst_i = 1'b1; load_i = 1'b0; vl_i = 12'd0; vstart_i = 12'd0; vm_i = 1'b1;
        red_mode_i = 2'b00; shift_en_i = 1'b0; mask_i = 8'h00; shift_partial_i = 1'b0;
        repeat (2) @(posedge clk);
        // reset state
        cyc(1'b1, 1'b0, 0, 0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);

        // vl=20, vstart=0, unmasked, no reduction
        ld_op(20, 0, 1'b1, 2'b00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h0F, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // vstart=5, vl=11 with a stall between the two groups
        ld_op(11, 5, 1'b1, 2'b00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hE0, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h07, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // vl=8 masked by AA; serial reduction exposes lane_used=AA
        ld_op(8, 0, 1'b0, 2'b01, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'hAA, 1'b0, 8'hAA, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h01, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 7'h04, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h04, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h10, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h40, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // serial reduction, vl=3
        ld_op(3, 0, 1'b1, 2'b01, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h07, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h01, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h02, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        end
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // tree reduction, vl=5
        ld_op(5, 0, 1'b1, 2'b10, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h1F, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h05, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h02, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 7'h08, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // empty ops: vl=0, then vstart>=vl
        ld_op(0, 0, 1'b1, 2'b00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);
        run(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        ld_op(9, 9, 1'b1, 2'b01, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // load during ACTIVE restarts at the new start group (mode 11 = none)
        ld_op(20, 0, 1'b1, 2'b11, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00, 1'b1, 1'b0);
        ld_op(30, 13, 1'b1, 2'b11, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hE0, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h3F, 1'b1, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b1);

        // reset in the middle of an op: back to idle, no done pulse
        ld_op(20, 0, 1'b1, 2'b00, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 7'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 1'b0);
        run(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);
        run(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 1'b0);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
